// File: rtl/sdram_arbiter_nport_if.sv
// Bundled request/ack ports of the N-reader / 1-writer SDRAM arbiter plus its Avalon bridge side.
// slave = arbiter view, master = requesters and bridge view.
interface sdram_arbiter_nport_if #(
  parameter int NUM_RD     = 3,
  parameter int ADDR_W     = 25,
  parameter int AVL_ADDR_W = 26,
  parameter int DATA_W     = 16
);
  logic                     wr_override;
  logic [NUM_RD-1:0]        rd_req;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]        rd_ack;
  logic [DATA_W-1:0]        rd_data;
  logic                     wr_req;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     wr_ack;
  logic [AVL_ADDR_W-1:0]    avl_addr;
  logic                     avl_read;
  logic                     avl_write;
  logic [DATA_W-1:0]        avl_wrdata;
  logic [DATA_W-1:0]        avl_rddata;
  logic                     avl_ack;
  logic [3:0]               grant_id;
  logic                     busy;
  logic                     timeout_err;

  modport slave (
    input  wr_override, rd_req, rd_addr, wr_req, wr_addr, wr_data, avl_rddata, avl_ack,
    output rd_ack, rd_data, wr_ack, avl_addr, avl_read, avl_write, avl_wrdata,
           grant_id, busy, timeout_err
  );

  modport master (
    output wr_override, rd_req, rd_addr, wr_req, wr_addr, wr_data, avl_rddata, avl_ack,
    input  rd_ack, rd_data, wr_ack, avl_addr, avl_read, avl_write, avl_wrdata,
           grant_id, busy, timeout_err
  );
endinterface

// File: rtl/sdram_arbiter_nport.sv
// Round-robin arbiter of NUM_RD readers plus one writer onto a single Avalon bridge port,
// with a write-override lockout and a per-transaction ack watchdog.
//
// state  | meaning
// IDLE   | no transaction; pick the next eligible port round-robin
// BUS    | strobe and address held, waiting for avl_ack or watchdog expiry
// DONE   | one-cycle port ack pulse, strobes low
module sdram_arbiter_nport #(
  parameter int NUM_RD      = 3,
  parameter int ADDR_W      = 25,
  parameter int AVL_ADDR_W  = 26,
  parameter int DATA_W      = 16,
  parameter int BYTE_SHIFT  = 1,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                  clk50,
  input  logic                  reset_n,
  sdram_arbiter_nport_if.slave  bus
);

  localparam int NP     = NUM_RD + 1;
  localparam int SH_W   = ADDR_W + BYTE_SHIFT;
  localparam int WIDE_W = (SH_W > AVL_ADDR_W) ? SH_W : AVL_ADDR_W;
  localparam int WD_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit WD_EN  = (TIMEOUT_CYC != 0);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [3:0] WR_IDX = 4'(NUM_RD);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  do_grant;
  logic                  do_done;
  logic                  do_abort;

  logic [3:0]            rr_ptr;
  logic [WD_W-1:0]       wd_cnt;
  logic [NP-1:0]         elig;
  logic                  win_found;
  logic [3:0]            win_idx;
  logic [ADDR_W-1:0]     win_addr;
  logic [WIDE_W-1:0]     win_wide;
  logic [AVL_ADDR_W-1:0] win_avl_addr;

  logic [NUM_RD-1:0]     rd_ack_q;
  logic [DATA_W-1:0]     rd_data_q;
  logic                  wr_ack_q;
  logic [AVL_ADDR_W-1:0] avl_addr_q;
  logic                  avl_read_q;
  logic                  avl_write_q;
  logic [DATA_W-1:0]     avl_wrdata_q;
  logic [3:0]            grant_q;
  logic                  timeout_q;

  function automatic logic [3:0] rr_index(input logic [3:0] ptr, input int off);
    return 4'((int'(ptr) + off) % NP);
  endfunction

  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      elig[k] = bus.rd_req[k] & ~bus.wr_override;
    end
    elig[NUM_RD] = bus.wr_req;
  end

  // Walk rr_ptr+1 .. rr_ptr+NP; the first eligible port wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 1; i <= NP; i++) begin
      for (int k = 0; k < NP; k++) begin
        if (!win_found && elig[k] && (rr_index(rr_ptr, i) == 4'(k))) begin
          win_found = 1'b1;
          win_idx   = 4'(k);
        end
      end
    end
  end

  always_comb begin
    win_addr = bus.wr_addr;
    for (int k = 0; k < NUM_RD; k++) begin
      if (win_idx == 4'(k)) begin
        win_addr = bus.rd_addr[k*ADDR_W +: ADDR_W];
      end
    end
    win_wide     = WIDE_W'(win_addr) << BYTE_SHIFT;
    win_avl_addr = win_wide[AVL_ADDR_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    do_grant = 1'b0;
    do_done  = 1'b0;
    do_abort = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          do_grant = 1'b1;
          state_d  = S_BUS;
        end
      end
      S_BUS: begin
        // A same-cycle ack beats the watchdog.
        if (bus.avl_ack) begin
          do_done = 1'b1;
          state_d = S_DONE;
        end else if (WD_EN && (wd_cnt == '0)) begin
          do_abort = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      rr_ptr       <= WR_IDX;
      wd_cnt       <= '0;
      rd_ack_q     <= '0;
      rd_data_q    <= '0;
      wr_ack_q     <= 1'b0;
      avl_addr_q   <= '0;
      avl_read_q   <= 1'b0;
      avl_write_q  <= 1'b0;
      avl_wrdata_q <= '0;
      grant_q      <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ack_q  <= '0;
      wr_ack_q  <= 1'b0;
      timeout_q <= 1'b0;

      if (do_grant) begin
        grant_q     <= win_idx;
        avl_addr_q  <= win_avl_addr;
        avl_read_q  <= (win_idx != WR_IDX);
        avl_write_q <= (win_idx == WR_IDX);
        wd_cnt      <= WD_LOAD;
        if (win_idx == WR_IDX) begin
          avl_wrdata_q <= bus.wr_data;
        end
      end

      if ((state_q == S_BUS) && !do_done && !do_abort && (wd_cnt != '0)) begin
        wd_cnt <= wd_cnt - 1'b1;
      end

      if (do_done) begin
        avl_read_q  <= 1'b0;
        avl_write_q <= 1'b0;
        rr_ptr      <= grant_q;
        if (avl_read_q) begin
          rd_data_q <= bus.avl_rddata;
        end
        for (int k = 0; k < NUM_RD; k++) begin
          rd_ack_q[k] <= (grant_q == 4'(k));
        end
        wr_ack_q <= (grant_q == WR_IDX);
      end

      if (do_abort) begin
        avl_read_q  <= 1'b0;
        avl_write_q <= 1'b0;
        rr_ptr      <= grant_q;
        timeout_q   <= 1'b1;
        wd_cnt      <= '0;
      end
    end
  end

  assign bus.rd_ack      = rd_ack_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.wr_ack      = wr_ack_q;
  assign bus.avl_addr    = avl_addr_q;
  assign bus.avl_read    = avl_read_q;
  assign bus.avl_write   = avl_write_q;
  assign bus.avl_wrdata  = avl_wrdata_q;
  assign bus.grant_id    = grant_q;
  assign bus.timeout_err = timeout_q;
  assign bus.busy        = (state_q != S_IDLE);

endmodule
